controle_multiciclo: RTL

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/controle_multiciclo.sv
// ============================================================================
// Module      : controle_multiciclo
// Description : Multicycle RISC-V control unit. A Moore FSM sequences each
//               instruction (lw, sw, R-type, I-ALU, beq, jal) through fetch,
//               decode, execute, memory and write-back states and drives the
//               datapath enables and mux selects.
//               Optional feature macro MEM_WAIT_EN: when defined, FETCH,
//               MEMREAD and MEMWRITE wait for mem_ready before advancing.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module controle_multiciclo #(
  parameter int ILLEGAL_HALT = 1
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] c_op_lw   = 7'b0000011;
  localparam logic [6:0] c_op_sw   = 7'b0100011;
  localparam logic [6:0] c_op_r    = 7'b0110011;
  localparam logic [6:0] c_op_i    = 7'b0010011;
  localparam logic [6:0] c_op_beq  = 7'b1100011;
  localparam logic [6:0] c_op_jal  = 7'b1101111;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic [2:0] w_funct_alu;
  logic       w_funct_bad;
  logic       w_mem_done;

`ifdef MEM_WAIT_EN
  assign w_mem_done = mem_ready;
`else
  // Memory is single-cycle in this build; mem_ready is intentionally unused.
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_done = 1'b1;
`endif

  // State and sticky illegal flag; reset aborts any instruction in flight.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // ALU operation for R-type and I-ALU; unsupported funct3 falls back to add.
  always_comb begin
    w_funct_alu = c_alu_add;
    w_funct_bad = 1'b0;
    case (funct3)
      3'b000:  w_funct_alu = (op[5] & funct7b5) ? c_alu_sub : c_alu_add;
      3'b010:  w_funct_alu = c_alu_slt;
      3'b110:  w_funct_alu = c_alu_or;
      3'b111:  w_funct_alu = c_alu_and;
      default: w_funct_bad = 1'b1;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (op)
      c_op_sw:  imm_src = 2'b01;
      c_op_beq: imm_src = 2'b10;
      c_op_jal: imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  // Next-state and per-state datapath controls; everything defaults inactive.
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    w_pc_write  = 1'b0;
    w_adr_src   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = c_alu_add;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = w_mem_done;
        w_pc_write = w_mem_done;
        state_d    = w_mem_done ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          c_op_lw, c_op_sw: state_d = S_MEMADR;
          c_op_r:           state_d = S_EXECUTER;
          c_op_i:           state_d = S_EXECUTEI;
          c_op_beq:         state_d = S_BEQ;
          c_op_jal:         state_d = S_JAL;
          default: begin
            illegal_d = 1'b1;
            state_d   = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == c_op_sw) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        state_d   = w_mem_done ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        state_d     = w_mem_done ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_control = w_funct_alu;
        if (w_funct_bad) illegal_d = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = c_alu_sub;
        w_pc_write  = zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
        state_d    = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are killed combinationally while reset is held so no write escapes.
  assign pc_write  = w_pc_write  & rst;
  assign adr_src   = w_adr_src   & rst;
  assign mem_write = w_mem_write & rst;
  assign ir_write  = w_ir_write  & rst;
  assign reg_write = w_reg_write & rst;
  assign illegal   = illegal_q;
  assign state     = state_q;

endmodule

`default_nettype wire
